// File: rtl/wt_arb_pkg.sv
// Shared constants and types for the wavetable ROM read arbiter:
// CSR word addresses, status register bit positions and the return-path tag.
package wt_arb_pkg;

  localparam logic [1:0] CSR_MASK   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_PERF   = 2'd2;

  // status word layout: bit0 = read in flight, [10:8] = last granted voice
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_LG_LSB   = 8;
  localparam int STATUS_LG_W     = 3;

  // wide enough for up to 8 voices
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] voice_id;
  } tag_t;

endpackage

// File: rtl/wavetable_read_arbiter_pick.sv
// Combinational round-robin selector: scans from last_grant+1, wrapping,
// and picks the first eligible voice. Grant is one-hot, zero if none eligible.
module wt_rr_pick #(
  parameter int NUM  = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM-1:0]  elig,
  input  logic [ID_W-1:0] last_grant,
  output logic [NUM-1:0]  gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic            found_s;
  logic [ID_W-1:0] cand_s;

  // rotating priority search starting just after the previous winner
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand_s = ID_W'((int'(last_grant) + k) % NUM);
      if (!found_s && elig[cand_s]) begin
        found_s      = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_id       = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wavetable_read_arbiter.sv
// Round-robin arbiter sharing one synchronous wavetable ROM between voices.
// Grants one request per cycle, registers the ROM address/strobe, tags each
// read with its voice ID through a ROM_LAT-deep pipe, and exposes an
// Avalon-MM CSR (enable mask, status, optional transfer counter).
// Optional feature macro: WTARB_PERF_CNT_EN (32-bit transfer counter at CSR 2).
module wavetable_read_arbiter
  import wt_arb_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 4,
  parameter int PHASE_W    = 8,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_VOICES-1:0]           voice_req,
  input  logic [NUM_VOICES*IDX_W-1:0]     voice_idx,
  input  logic [NUM_VOICES*PHASE_W-1:0]   voice_phase,
  output logic [NUM_VOICES-1:0]           voice_gnt,
  output logic [IDX_W+PHASE_W-1:0]        rom_addr,
  output logic                            rom_rd,
  input  logic [DATA_W-1:0]               rom_q,
  output logic                            rd_valid,
  output logic [$clog2(NUM_VOICES)-1:0]   rd_voice,
  output logic [DATA_W-1:0]               rd_data,
  input  logic [1:0]                      csr_address,
  input  logic                            csr_chipselect,
  input  logic                            csr_write_n,
  input  logic [31:0]                     csr_writedata,
  output logic [31:0]                     csr_readdata
);

  localparam int VID_W  = $clog2(NUM_VOICES);
  localparam int ADDR_W = IDX_W + PHASE_W;

  logic [NUM_VOICES-1:0] enable_mask_q, enable_mask_d;
  logic [VID_W-1:0]      last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic                  rom_rd_q, rom_rd_d;
  tag_t [ROM_LAT-1:0]    tag_q, tag_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [VID_W-1:0]      rd_voice_q, rd_voice_d;

  logic [NUM_VOICES-1:0] elig_s, gnt_s;
  logic [VID_W-1:0]      gnt_id_s;
  logic                  xfer_s, csr_we_s, busy_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic [PHASE_W-1:0]    sel_phase_s;
  logic                  unused_s;

  // the registered mask is used, so a CSR write never affects the same cycle's grant
  assign elig_s   = voice_req & enable_mask_q;
  assign xfer_s   = |(voice_req & gnt_s);
  assign csr_we_s = csr_chipselect & ~csr_write_n;
  assign unused_s = ^{csr_writedata, tag_q[ROM_LAT-1].voice_id};

  wt_rr_pick #(
    .NUM  (NUM_VOICES),
    .ID_W (VID_W)
  ) u_pick (
    .elig       (elig_s),
    .last_grant (last_grant_q),
    .gnt        (gnt_s),
    .gnt_id     (gnt_id_s)
  );

  assign voice_gnt = gnt_s;
  assign rom_addr  = rom_addr_q;
  assign rom_rd    = rom_rd_q;
  assign rd_valid  = rd_valid_q;
  assign rd_voice  = rd_voice_q;
  assign rd_data   = rom_q;

  // AND-OR mux of the winning voice's table index and phase (grant is one-hot)
  always_comb begin
    sel_idx_s   = '0;
    sel_phase_s = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sel_idx_s   = sel_idx_s   | ({IDX_W{gnt_s[v]}}   & voice_idx[v*IDX_W +: IDX_W]);
      sel_phase_s = sel_phase_s | ({PHASE_W{gnt_s[v]}} & voice_phase[v*PHASE_W +: PHASE_W]);
    end
  end

  // next state for grant history, ROM port, tag pipe, return path and mask
  always_comb begin
    last_grant_d = last_grant_q;
    rom_addr_d   = rom_addr_q;
    rom_rd_d     = xfer_s;
    if (xfer_s) begin
      last_grant_d = gnt_id_s;
      rom_addr_d   = {sel_idx_s, sel_phase_s};
    end else begin
      rom_addr_d   = rom_addr_q;
    end
    tag_d[0].valid    = xfer_s;
    tag_d[0].voice_id = TAG_ID_W'(gnt_id_s);
    for (int k = 1; k < ROM_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rd_valid_d = tag_q[ROM_LAT-1].valid;
    rd_voice_d = tag_q[ROM_LAT-1].voice_id[VID_W-1:0];
    if (csr_we_s && (csr_address == CSR_MASK)) begin
      enable_mask_d = csr_writedata[NUM_VOICES-1:0];
    end else begin
      enable_mask_d = enable_mask_q;
    end
  end

  // state registers; reset drops all in-flight tags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_mask_q <= '1;
      last_grant_q  <= VID_W'(NUM_VOICES - 1);
      rom_addr_q    <= '0;
      rom_rd_q      <= 1'b0;
      tag_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_voice_q    <= '0;
    end else begin
      enable_mask_q <= enable_mask_d;
      last_grant_q  <= last_grant_d;
      rom_addr_q    <= rom_addr_d;
      rom_rd_q      <= rom_rd_d;
      tag_q         <= tag_d;
      rd_valid_q    <= rd_valid_d;
      rd_voice_q    <= rd_voice_d;
    end
  end

  // any read still travelling through the tag pipe
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k < ROM_LAT; k++) begin
      busy_s = busy_s | tag_q[k].valid;
    end
  end

`ifdef WTARB_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // transfer counter; a clear wins over a coincident transfer
  always_comb begin
    if (csr_we_s && (csr_address == CSR_PERF)) begin
      perf_cnt_d = 32'd0;
    end else if (xfer_s) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // transfer counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end
`endif

  // zero-latency CSR read mux
  always_comb begin
    csr_readdata = 32'd0;
    case (csr_address)
      CSR_MASK: begin
        csr_readdata[NUM_VOICES-1:0] = enable_mask_q;
      end
      CSR_STATUS: begin
        csr_readdata[STATUS_BUSY_BIT]                 = busy_s;
        csr_readdata[STATUS_LG_LSB +: STATUS_LG_W]    = STATUS_LG_W'(last_grant_q);
      end
      CSR_PERF: begin
`ifdef WTARB_PERF_CNT_EN
        csr_readdata = perf_cnt_q;
`else
        csr_readdata = 32'd0;
`endif
      end
      default: begin
        csr_readdata = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_wavetable_read_arbiter.sv
// Self-checking bench for wavetable_read_arbiter: randomized voice traffic and
// CSR accesses against a behavioural model; returned samples are checked by a
// scoreboard monitor with exact arrival cycle.
module tb_wavetable_read_arbiter;

  localparam int NV = 4;
  localparam int IW = 4;
  localparam int PW = 8;
  localparam int DW = 16;
  localparam int RL = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NV-1:0]        voice_req = '0;
  logic [NV*IW-1:0]     voice_idx = '0;
  logic [NV*PW-1:0]     voice_phase = '0;
  logic [NV-1:0]        voice_gnt;
  logic [IW+PW-1:0]     rom_addr;
  logic                 rom_rd;
  logic [DW-1:0]        rom_q;
  logic                 rd_valid;
  logic [$clog2(NV)-1:0] rd_voice;
  logic [DW-1:0]        rd_data;
  logic [1:0]           csr_address = 2'd0;
  logic                 csr_chipselect = 1'b0;
  logic                 csr_write_n = 1'b1;
  logic [31:0]          csr_writedata = 32'd0;
  logic [31:0]          csr_readdata;

  wavetable_read_arbiter #(
    .NUM_VOICES(NV), .IDX_W(IW), .PHASE_W(PW), .DATA_W(DW), .ROM_LAT(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .voice_req(voice_req), .voice_idx(voice_idx),
    .voice_phase(voice_phase), .voice_gnt(voice_gnt), .rom_addr(rom_addr),
    .rom_rd(rom_rd), .rom_q(rom_q), .rd_valid(rd_valid), .rd_voice(rd_voice),
    .rd_data(rd_data), .csr_address(csr_address), .csr_chipselect(csr_chipselect),
    .csr_write_n(csr_write_n), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents are a simple function of the address
  function automatic logic [DW-1:0] rom_fn(input logic [IW+PW-1:0] a);
    return DW'(a) * 16'd37 + 16'h1234;
  endfunction

  // synchronous ROM with RL cycles of read latency
  logic [DW-1:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_rd ? rom_fn(rom_addr) : 16'hDEAD;
    for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_pipe[RL-1];

  typedef struct { int v; logic [DW-1:0] d; int due; } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  // model state
  logic [NV-1:0]  m_mask = '1;
  int             m_last = NV - 1;
  logic [31:0]    m_perf = 32'd0;
  logic           exp_rd = 1'b0;
  logic [IW+PW-1:0] exp_addr = '0;
  logic           req_a [NV];
  logic [IW-1:0]  idx_a [NV];
  logic [PW-1:0]  ph_a  [NV];
  int             mode = 3;   // 0 random, 1 all continuous, 2 one-shot, 3 idle

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic model_busy();
    foreach (exp_q[i]) if (cyc < exp_q[i].due && cyc >= exp_q[i].due - RL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_csr(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0: r = {28'd0, m_mask};
      2'd1: begin r[0] = model_busy(); r[10:8] = 3'(m_last); end
`ifdef WTARB_PERF_CNT_EN
      2'd2: r = m_perf;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic new_req(input int v, input logic r);
    req_a[v] = r;
    idx_a[v] = IW'($urandom);
    ph_a[v]  = PW'($urandom);
  endtask

  task automatic all_req();
    for (int v = 0; v < NV; v++) new_req(v, 1'b1);
  endtask

  // scoreboard monitor: compares every returned sample, flags overdue ones
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_total++;
      $display("FAIL rd_missing: no sample for voice %0d, expected at cycle %0d", exp_q[0].v, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: voice %0d data %0h, expected none (cycle %0d)", rd_voice, rd_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rd_return {cycle,voice,data}", {32'(cyc), 16'(rd_voice), rd_data},
              {32'(e.due), 16'(e.v), e.d});
      end
    end
  end

  // one clock cycle of stimulus; entered and left just after a falling edge
  task automatic step(input logic [1:0] a, input logic cs, input logic wr, input logic [31:0] wd);
    logic [NV-1:0] egnt;
    int eid;
    bit found;
    for (int v = 0; v < NV; v++) begin
      voice_req[v]             = req_a[v];
      voice_idx[v*IW +: IW]    = idx_a[v];
      voice_phase[v*PW +: PW]  = ph_a[v];
    end
    csr_address    = a;
    csr_chipselect = cs;
    csr_write_n    = ~wr;
    csr_writedata  = wd;
    #1;
    check("rom_rd", 64'(rom_rd), 64'(exp_rd));
    check("rom_addr", 64'(rom_addr), 64'(exp_addr));
    egnt = '0; eid = 0; found = 0;
    for (int k = 1; k <= NV; k++) begin
      int c;
      c = (m_last + k) % NV;
      if (!found && req_a[c] && m_mask[c]) begin found = 1; eid = c; end
    end
    if (found) egnt[eid] = 1'b1;
    check("voice_gnt", 64'(voice_gnt), 64'(egnt));
    if (cs && !wr) check($sformatf("csr_read[%0d]", a), 64'(csr_readdata), 64'(model_csr(a)));
    if (found) begin
      exp_q.push_back('{v: eid, d: rom_fn({idx_a[eid], ph_a[eid]}), due: cyc + 1 + RL});
      exp_addr = {idx_a[eid], ph_a[eid]};
      exp_rd   = 1'b1;
      m_last   = eid;
      m_perf   = m_perf + 32'd1;
    end else begin
      exp_rd = 1'b0;
    end
    for (int v = 0; v < NV; v++) begin
      if (found && v == eid) begin
        case (mode)
          1: new_req(v, 1'b1);
          0: new_req(v, 1'($urandom_range(0, 1)));
          default: req_a[v] = 1'b0;
        endcase
      end else if (!req_a[v] && mode == 0 && $urandom_range(0, 2) == 0) begin
        new_req(v, 1'b1);
      end
    end
    if (cs && wr) begin
      if (a == 2'd0) m_mask = wd[NV-1:0];
      if (a == 2'd2) m_perf = 32'd0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    voice_req = '0;
    for (int v = 0; v < NV; v++) req_a[v] = 1'b0;
    exp_q.delete();
    m_last = NV - 1; m_mask = '1; m_perf = 32'd0;
    exp_rd = 1'b0; exp_addr = '0;
    #1;
    check("reset rom_rd", 64'(rom_rd), 64'd0);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset rom_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d checks made", n_total);
    $fatal(1, "timeout");
  end

  initial begin
    for (int v = 0; v < NV; v++) begin req_a[v] = 1'b0; idx_a[v] = '0; ph_a[v] = '0; end
    repeat (2) @(negedge clk);
    // reset state
    csr_chipselect = 1'b1; csr_address = 2'd0;
    #1;
    check("reset mask", 64'(csr_readdata), 64'h0000000F);
    check("reset gnt", 64'(voice_gnt), 64'd0);
    check("reset rom_rd", 64'(rom_rd), 64'd0);
    check("reset rd_valid/voice", 64'({rd_valid, rd_voice}), 64'd0);
    csr_address = 2'd1;
    #1;
    check("reset status", 64'(csr_readdata), 64'h00000300);
    csr_chipselect = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // single voice 0 read: idx 3, phase 0x10
    mode = 2;
    req_a[0] = 1'b1; idx_a[0] = 4'h3; ph_a[0] = 8'h10;
    step(2'd0, 1'b1, 1'b0, 32'd0);
    check("rom_addr single", 64'(rom_addr), 64'h310);
    step(2'd1, 1'b1, 1'b0, 32'd0);   // status while in flight
    repeat (4) step(2'd3, 1'b1, 1'b0, 32'd0);
    step(2'd1, 1'b1, 1'b0, 32'd0);   // status after drain

    // all voices continuously
    mode = 1; all_req();
    repeat (12) step(2'd0, 1'b0, 1'b0, 32'd0);
    // mask to voices 0 and 2
    step(2'd0, 1'b1, 1'b1, 32'hFFFF_FFF5);
    repeat (8) step(2'd0, 1'b1, 1'b0, 32'd0);
    step(2'd0, 1'b1, 1'b1, 32'h0000_000F);
    repeat (3) step(2'd0, 1'b0, 1'b0, 32'd0);

    // reset with reads in flight
    do_reset();
    mode = 1; all_req();
    repeat (10) step(2'd1, 1'b1, 1'b0, 32'd0);
    step(2'd2, 1'b1, 1'b0, 32'd0);   // counter after 10 transfers
    step(2'd2, 1'b1, 1'b1, 32'd0);   // clear coinciding with a transfer
    step(2'd2, 1'b1, 1'b0, 32'd0);
    step(2'd3, 1'b1, 1'b0, 32'd0);

    // randomized traffic and CSR accesses
    mode = 0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      step(2'd0, 1'b1, 1'b1, $urandom);
      else if (r == 1) step(2'd2, 1'b1, 1'b1, $urandom);
      else if (r <= 5) step(2'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0);
      else             step(2'd0, 1'b0, 1'b0, 32'd0);
    end

    // drain
    mode = 3;
    for (int v = 0; v < NV; v++) req_a[v] = 1'b0;
    repeat (8) step(2'd0, 1'b0, 1'b0, 32'd0);
    step(2'd1, 1'b1, 1'b0, 32'd0);
    check("drain queue empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
